// File: rtl/gate_sweep_checker_pkg.sv
// gate_sweep_checker_pkg
// Shared definitions for the gate sweep checker.
// It holds the gate bit positions within gate_vec, the golden response table
// indexed by {A,B}, and the checker state encoding.
package gate_sweep_checker_pkg;

    localparam int GATE_W = 7;

    // Bit positions of each gate output within gate_vec.
    localparam int AND_B  = 6;
    localparam int OR_B   = 5;
    localparam int NOTA_B = 4;
    localparam int NOR_B  = 3;
    localparam int XOR_B  = 2;
    localparam int XNOR_B = 1;
    localparam int NAND_B = 0;

    typedef logic [GATE_W-1:0] gate_vec_t;

    // Golden gate-unit response, indexed by {A,B}.
    localparam gate_vec_t EXPECT_TBL [4] = '{
        7'h1B,  // AB=00
        7'h35,  // AB=01
        7'h25,  // AB=10
        7'h62   // AB=11
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/gate_sweep_checker_if.sv
// gate_sweep_checker_if
// Bundles the checker's control, status and gate-unit signals.
//   master : the checker. It takes start and gate_vec, and drives
//            a_out/b_out and the sweep status and results.
//   slave  : the environment. It drives start and the gate-unit outputs,
//            and observes the results.
interface gate_sweep_checker_if;
    import gate_sweep_checker_pkg::*;

    logic      start;
    gate_vec_t gate_vec;
    logic      a_out;
    logic      b_out;
    logic      busy;
    logic      done;
    logic      pass;
    logic [2:0] err_count;
    gate_vec_t err_mask;

    modport master (
        input  start, gate_vec,
        output a_out, b_out, busy, done, pass, err_count, err_mask
    );

    modport slave (
        output start, gate_vec,
        input  a_out, b_out, busy, done, pass, err_count, err_mask
    );

endinterface

// File: rtl/gate_sweep_checker_expect.sv
// gate_expect
// Combinational golden model. It maps the 2-bit vector index {A,B} to the
// expected 7-bit gate-unit response.
//   idx     : current vector index {A,B}
//   exp_vec : expected gate_vec for that vector
module gate_expect
    import gate_sweep_checker_pkg::*;
(
    input  logic [1:0] idx,
    output gate_vec_t  exp_vec
);

    assign exp_vec = EXPECT_TBL[idx];

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
// Stimulus/response engine for the two-input basic gate unit.
// A start pulse launches one sweep. The sweep drives AB = 00, 01, 10, 11 and
// holds each vector for SETTLE cycles. At the end of each hold it samples
// gate_vec against the golden model. When the sweep ends, done pulses and
// pass / err_count / err_mask are updated.
//   clk, rst : clock and synchronous active-high reset
//   bus      : start and gate_vec in; a_out/b_out, busy, done, pass,
//              err_count and err_mask out (all registered)
//
// state | meaning
// IDLE  | waiting for start; results of the last sweep held
// RUN   | vector idx applied, settle counter running, sample at count 0
module gate_sweep_checker
    import gate_sweep_checker_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    gate_sweep_checker_if.master bus
);

    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
        $error("gate_sweep_checker: SETTLE must be within 1..255");
    end

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_count_q, err_count_d;
    gate_vec_t  err_mask_q, err_mask_d;

    gate_vec_t  exp_vec;
    gate_vec_t  mism;
    logic [2:0] count_next;

    gate_expect u_expect (
        .idx     (idx_q),
        .exp_vec (exp_vec)
    );

    assign mism       = bus.gate_vec ^ exp_vec;
    assign count_next = err_count_q + 3'(|mism);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        err_mask_d  = err_mask_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_RUN;
                    idx_d       = 2'd0;
                    cnt_d       = SETTLE_LD;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    err_count_d = '0;
                    err_mask_d  = '0;
                end
            end
            ST_RUN: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    err_mask_d  = err_mask_q | mism;
                    err_count_d = count_next;
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                        cnt_d = SETTLE_LD;
                    end else begin
                        // Last sample: idx returns to 0, so the gate inputs
                        // return to 0 together with the done pulse.
                        state_d = ST_IDLE;
                        idx_d   = 2'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (count_next == 3'd0);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 3'd0;
            err_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            err_mask_q  <= err_mask_d;
        end
    end

    // idx is 0 whenever the block is idle, so the registered index is the
    // applied vector itself.
    assign bus.a_out     = idx_q[1];
    assign bus.b_out     = idx_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_count_q;
    assign bus.err_mask  = err_mask_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gate_sweep_checker_if if1 ();
    gate_sweep_checker_if if3 ();

    gate_sweep_checker #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));
    gate_sweep_checker #(.SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.master));

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural gate unit with fault injection: per-vector bit flips and
    // a stuck-at-0 mask.
    logic [6:0] flip [4];
    logic [6:0] stuck_and;
    logic       use_delay1;
    logic [6:0] u1, u3, p1a, p1b, p3a, p3b;

    function automatic logic [6:0] golden(input logic a, input logic b);
        return {a & b, a | b, ~a, ~(a | b), a ^ b, ~(a ^ b), ~(a & b)};
    endfunction

    assign u1 = (golden(if1.a_out, if1.b_out) ^ flip[{if1.a_out, if1.b_out}]) & stuck_and;
    assign u3 = (golden(if3.a_out, if3.b_out) ^ flip[{if3.a_out, if3.b_out}]) & stuck_and;

    // Two register stages model a pipelined gate unit.
    always @(posedge clk) begin
        p1a <= u1;
        p1b <= p1a;
        p3a <= u3;
        p3b <= p3a;
    end

    assign if1.gate_vec = use_delay1 ? p1b : u1;
    assign if3.gate_vec = p3b;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: what a sweep should report for the current fault setup.
    task automatic predict(output logic [2:0] cnt, output logic [6:0] mask, output logic ok);
        logic [6:0] seen, m;
        logic [1:0] v;
        cnt  = 0;
        mask = 0;
        for (int i = 0; i < 4; i++) begin
            v    = 2'(i);
            seen = (golden(v[1], v[0]) ^ flip[v]) & stuck_and;
            m    = seen ^ golden(v[1], v[0]);
            mask = mask | m;
            if (m != 0) cnt = cnt + 3'd1;
        end
        ok = (cnt == 0);
    endtask

    task automatic clear_faults;
        for (int i = 0; i < 4; i++) flip[i] = 7'h00;
        stuck_and = 7'h7F;
    endtask

    // Launch a sweep on dut1 and wait (bounded) for done.
    task automatic run_sweep1(input string name);
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        for (int k = 0; k < 20 && !if1.done; k++) tick();
        n_checks++;
        if (if1.done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_timeout: done=%b required 1", name, if1.done);
        end
    endtask

    task automatic check_results1(input string name);
        logic [2:0] ec;
        logic [6:0] em;
        logic       ep;
        predict(ec, em, ep);
        n_checks++;
        if ({if1.pass, if1.err_count, if1.err_mask} !== {ep, ec, em}) begin
            n_fail++;
            $display("FAIL %s: pass/cnt/mask=%b/%0d/%h required %b/%0d/%h",
                     name, if1.pass, if1.err_count, if1.err_mask, ep, ec, em);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        if1.start = 1'b0;
        if3.start = 1'b0;
        use_delay1 = 1'b0;
        clear_faults();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({if1.a_out, if1.b_out, if1.busy, if1.done, if1.pass, if1.err_count, if1.err_mask} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_dut1: outputs=%h required 0",
                     {if1.a_out, if1.b_out, if1.busy, if1.done, if1.pass, if1.err_count, if1.err_mask});
        end
        n_checks++;
        if ({if3.a_out, if3.b_out, if3.busy, if3.done, if3.pass, if3.err_count, if3.err_mask} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_dut3: outputs=%h required 0",
                     {if3.a_out, if3.b_out, if3.busy, if3.done, if3.pass, if3.err_count, if3.err_mask});
        end
    endtask

    task automatic test_clean_sweep;
        clear_faults();
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            n_checks++;
            if ({if1.a_out, if1.b_out, if1.busy, if1.done} !== {2'(c), 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL clean_vec%0d: ab/busy/done=%b%b/%b/%b required %b/1/0",
                         c, if1.a_out, if1.b_out, if1.busy, if1.done, 2'(c));
            end
        end
        tick();
        n_checks++;
        if ({if1.done, if1.busy, if1.a_out, if1.b_out} !== 4'b1000) begin
            n_fail++;
            $display("FAIL clean_end: done/busy/a/b=%b%b%b%b required 1000",
                     if1.done, if1.busy, if1.a_out, if1.b_out);
        end
        check_results1("clean_result");
        tick();
        n_checks++;
        if (if1.done !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_done_width: done=%b required 0", if1.done);
        end
    endtask

    task automatic test_stuck_xor;
        clear_faults();
        stuck_and = ~7'h04;
        run_sweep1("stuck_xor");
        check_results1("stuck_xor_result");
        n_checks++;
        if ({if1.err_count, if1.err_mask} !== {3'd2, 7'h04}) begin
            n_fail++;
            $display("FAIL stuck_xor_const: cnt/mask=%0d/%h required 2/04", if1.err_count, if1.err_mask);
        end
        tick();
    endtask

    task automatic test_random_faults;
        for (int it = 0; it < 12; it++) begin
            stuck_and = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h7F;
            for (int i = 0; i < 4; i++)
                flip[i] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00;
            run_sweep1("random");
            check_results1("random_result");
            repeat ($urandom_range(0, 3)) tick();
        end
        clear_faults();
    endtask

    task automatic test_slow_settle;
        clear_faults();
        repeat (3) tick();
        if3.start = 1'b1;
        tick();
        if3.start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) tick();
            n_checks++;
            if ({if3.a_out, if3.b_out, if3.busy, if3.done} !== {2'(c / 3), 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL slow_cycle%0d: ab/busy/done=%b%b/%b/%b required %b/1/0",
                         c, if3.a_out, if3.b_out, if3.busy, if3.done, 2'(c / 3));
            end
        end
        tick();
        n_checks++;
        if ({if3.done, if3.busy, if3.pass, if3.err_count, if3.err_mask} !== {3'b101, 3'd0, 7'h00}) begin
            n_fail++;
            $display("FAIL slow_end: done/busy/pass/cnt/mask=%b/%b/%b/%0d/%h required 1/0/1/0/00",
                     if3.done, if3.busy, if3.pass, if3.err_count, if3.err_mask);
        end
        // The same pipelined unit is too slow for SETTLE=1.
        use_delay1 = 1'b1;
        repeat (3) tick();
        run_sweep1("slow_on_settle1");
        n_checks++;
        if (if1.pass !== 1'b0) begin
            n_fail++;
            $display("FAIL slow_on_settle1_pass: pass=%b required 0", if1.pass);
        end
        use_delay1 = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_start_handling;
        logic [2:0] ec;
        logic [6:0] em;
        logic       ep;
        logic [1:0] eab;
        logic       ebusy, edone;
        clear_faults();
        stuck_and = ~7'h04;
        predict(ec, em, ep);
        if1.start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            ebusy = (c <= 3) || (c >= 5 && c <= 8);
            edone = (c == 4) || (c == 9);
            eab   = (c <= 3) ? 2'(c) : (c >= 5 && c <= 8) ? 2'(c - 5) : 2'd0;
            n_checks++;
            if ({if1.busy, if1.done, if1.a_out, if1.b_out} !== {ebusy, edone, eab}) begin
                n_fail++;
                $display("FAIL start_held_cycle%0d: busy/done/ab=%b/%b/%b%b required %b/%b/%b",
                         c, if1.busy, if1.done, if1.a_out, if1.b_out, ebusy, edone, eab);
            end
            if (c == 4) begin
                n_checks++;
                if ({if1.err_count, if1.err_mask} !== {ec, em}) begin
                    n_fail++;
                    $display("FAIL start_first_result: cnt/mask=%0d/%h required %0d/%h",
                             if1.err_count, if1.err_mask, ec, em);
                end
            end
            if (c == 5) begin
                n_checks++;
                if ({if1.pass, if1.err_count, if1.err_mask} !== 11'd0) begin
                    n_fail++;
                    $display("FAIL start_restart_clear: pass/cnt/mask=%b/%0d/%h required 0/0/00",
                             if1.pass, if1.err_count, if1.err_mask);
                end
            end
        end
        if1.start = 1'b0;
        check_results1("start_second_result");
        tick();
        n_checks++;
        if ({if1.busy, if1.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_no_third: busy/done=%b/%b required 0/0", if1.busy, if1.done);
        end
        clear_faults();
    endtask

    task automatic test_reset_mid_sweep;
        clear_faults();
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({if1.busy, if1.done, if1.a_out, if1.b_out} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid: busy/done/a/b=%b%b%b%b required 0000",
                     if1.busy, if1.done, if1.a_out, if1.b_out);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if ({if1.busy, if1.done} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_mid_quiet%0d: busy/done=%b/%b required 0/0", c, if1.busy, if1.done);
            end
        end
        run_sweep1("after_reset");
        n_checks++;
        if (if1.pass !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset_pass: pass=%b required 1", if1.pass);
        end
        tick();
    endtask

    task automatic test_persistence;
        logic [2:0] ec;
        logic [6:0] em;
        logic       ep;
        clear_faults();
        flip[0] = 7'h41;
        flip[3] = 7'h10;
        predict(ec, em, ep);
        run_sweep1("persist");
        clear_faults();
        for (int c = 0; c < 15; c++) begin
            tick();
            n_checks++;
            if ({if1.pass, if1.err_count, if1.err_mask} !== {ep, ec, em}) begin
                n_fail++;
                $display("FAIL persist_cycle%0d: pass/cnt/mask=%b/%0d/%h required %b/%0d/%h",
                         c, if1.pass, if1.err_count, if1.err_mask, ep, ec, em);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_sweep();
        test_stuck_xor();
        test_random_faults();
        test_slow_settle();
        test_start_handling();
        test_reset_mid_sweep();
        test_persistence();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-checking stimulus/response engine for the two-input basic gate unit. On a start pulse it drives the gate unit's A/B inputs through all four combinations. For each combination it samples the unit's seven gate outputs and compares them with a golden model. When the sweep ends it reports pass/fail, the number of failing vectors and a mask of the failing gates. It sits opposite the gate unit, driving its inputs and consuming its outputs, and is used for board-level self-test and bench regression.

## Interface

Parameters:
- SETTLE, default 1: cycles each vector is held before it is sampled. Legal range 1..255.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: sampled in IDLE; launches one sweep.
- gate_vec, input, 7: outputs of the gate unit. Bit mapping is [6] and, [5] or, [4] not(A), [3] nor, [2] xor, [1] xnor, [0] nand.
- a_out, output, 1: drives gate unit input A (registered).
- b_out, output, 1: drives gate unit input B (registered).
- busy, output, 1: high while a sweep is in progress.
- done, output, 1: one-cycle pulse when a sweep completes.
- pass, output, 1: result of the last sweep; high means all vectors matched.
- err_count, output, 3: number of vectors with at least one mismatching bit (0..4).
- err_mask, output, 7: bitwise OR of per-bit mismatches over the last sweep.

## Operation

- States: IDLE and RUN.
  - IDLE with start=1: clear err_count, err_mask and pass. Set idx=0 and drive {a_out,b_out}=idx. Load the settle counter with SETTLE-1. Go to RUN.
  - RUN: while the counter is nonzero, decrement it. When the counter is 0, sample gate_vec:
    - mism = gate_vec ^ expected(idx).
    - err_mask |= mism.
    - err_count += (mism != 0).
  - If idx < 3: increment idx, drive the new vector, reload the counter.
  - If idx == 3: go to IDLE, pulse done, register pass = (final err_count == 0), and return a_out/b_out to 0.
- Vector order is idx 0..3 with a_out = idx[1] and b_out = idx[0].
- Expected values:
  - AB=00: 7'h1B
  - AB=01: 7'h35
  - AB=10: 7'h25
  - AB=11: 7'h62
- start is ignored while busy.
- A start in the same cycle as done is accepted, because the block is already in IDLE.
- pass, err_count and err_mask hold until the next accepted start.
- Reset values: all outputs 0, state IDLE, idx 0.
- rst asserted mid-sweep aborts the sweep. No done pulse is produced, and all outputs return to their reset values on the next edge.

## Timing

- The start edge (E0) applies vector 0.
- Vector k is applied at edge E0 + k·SETTLE and sampled at edge E0 + (k+1)·SETTLE. The sample edge of vector k also applies vector k+1.
- At edge E0 + 4·SETTLE:
  - done=1 for exactly one cycle.
  - busy=0.
  - pass, err_count and err_mask are final.
- busy is high from edge E0 through the last sample edge, which is 4·SETTLE cycles.
- gate_vec must be stable for SETTLE cycles after each a_out/b_out change. A combinational gate unit needs SETTLE=1. A gate unit with N register stages needs SETTLE ≥ N+1.

## Structure

- Shared package holds:
  - gate bit index constants (AND_B … NAND_B);
  - the four-entry expected-vector table;
  - state encoding (IDLE, RUN).
- One sub-module: gate_expect, a combinational golden model mapping the 2-bit idx to the 7-bit expected value, built from the package table.
- The checker FSM, settle counter and accumulators stay in gate_sweep_checker.

## Test plan

- **Clean sweep.** SETTLE=1, connected to a correct gate unit, start pulsed at E0 → {a_out,b_out} reads 00, 01, 10, 11 on cycles 1 to 4; done at E0+4; pass=1, err_count=0, err_mask=0.
- **Stuck xor.** xor bit forced to 0 → vectors 01 and 10 fail; err_count=2, err_mask=7'h04, pass=0.
- **Slow settle.** SETTLE=3, DUT delayed by two register stages → each vector held 3 cycles; done at E0+12; pass=1. The same DUT with SETTLE=1 → pass=0.
- **Start handling.** start held high for 10 cycles → start is ignored while busy. A second start coincident with done launches an immediate new sweep, which clears err_count and err_mask at its start edge.
- **Reset mid-sweep.** rst asserted at E0+2 → next edge: busy=0, a_out=b_out=0, no done pulse. A following start completes normally with pass=1.
- **Result persistence.** A failing sweep followed by idle cycles → pass, err_count and err_mask hold unchanged until the next start.
